// File: rtl/pc_exec_controller.sv
// Purpose: sequences the IF-stage start pulse and pipeline enable for the debug unit (RUN/STEP/ABORT).
// Latency: command accept -> START next cycle; first RUN enable 2 cycles after accept; halt drops enable next cycle.
// Backpressure: o_cmd_ready low in START/STEP_PULSE, in IDLE without a program, and in END while halt is held.
module pc_exec_controller #(
    parameter int CYCLE_COUNT_SIZE = 32
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_cmd_valid,
    input  logic [1:0]                  i_cmd,
    output logic                        o_cmd_ready,
    input  logic                        i_program_ready,
    input  logic                        i_halt,
    output logic                        o_start,
    output logic                        o_enable,
    output logic                        o_running,
    output logic                        o_end,
    output logic [CYCLE_COUNT_SIZE-1:0] o_cycle_count
);

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    localparam logic [CYCLE_COUNT_SIZE-1:0] CNT_ONE = {{(CYCLE_COUNT_SIZE-1){1'b0}}, 1'b1};
    localparam logic [CYCLE_COUNT_SIZE-1:0] CNT_MAX = {CYCLE_COUNT_SIZE{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_RUN        = 3'd2,
        S_STEP_WAIT  = 3'd3,
        S_STEP_PULSE = 3'd4,
        S_END        = 3'd5
    } state_t;

    // Mode only matters when leaving START: continuous RUN or single STEP.
    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_STEP = 1'b1
    } mode_t;

    state_t                        state_q, state_d;
    mode_t                         mode_q, mode_d;
    logic [CYCLE_COUNT_SIZE-1:0]   count_q;
    logic                          cmd_rdy;
    logic                          cmd_fire;
    logic                          count_clr;
    logic                          count_en;

    // Command acceptance window, decoded from state (and halt while in END).
    always_comb begin
        cmd_rdy = 1'b1;
        case (state_q)
            S_IDLE:       cmd_rdy = i_program_ready;
            S_START:      cmd_rdy = 1'b0;
            S_STEP_PULSE: cmd_rdy = 1'b0;
            S_END:        cmd_rdy = ~i_halt;
            default:      cmd_rdy = 1'b1;
        endcase
    end

    assign o_cmd_ready = cmd_rdy;
    assign cmd_fire    = i_cmd_valid & cmd_rdy;

    // Next-state and mode selection; unhandled commands are consumed without effect.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        count_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    case (i_cmd)
                        CMD_RUN: begin
                            state_d   = S_START;
                            mode_d    = MODE_RUN;
                            count_clr = 1'b1;
                        end
                        CMD_STEP: begin
                            state_d   = S_START;
                            mode_d    = MODE_STEP;
                            count_clr = 1'b1;
                        end
                        CMD_NOP, CMD_ABORT: state_d = S_IDLE;
                        default:            state_d = S_IDLE;
                    endcase
                end
            end
            // One cycle with enable low so the PC leaves its idle state first.
            S_START: begin
                state_d = (mode_q == MODE_STEP) ? S_STEP_WAIT : S_RUN;
            end
            // ABORT takes priority over a halt seen in the same cycle.
            S_RUN: begin
                if (cmd_fire && i_cmd == CMD_ABORT) begin
                    state_d = S_IDLE;
                end else if (i_halt) begin
                    state_d = S_END;
                end
            end
            S_STEP_WAIT: begin
                if (cmd_fire) begin
                    case (i_cmd)
                        CMD_STEP:  state_d = S_STEP_PULSE;
                        CMD_RUN: begin
                            state_d = S_RUN;
                            mode_d  = MODE_RUN;
                        end
                        CMD_ABORT: state_d = S_IDLE;
                        default:   state_d = S_STEP_WAIT;
                    endcase
                end
            end
            S_STEP_PULSE: begin
                state_d = i_halt ? S_END : S_STEP_WAIT;
            end
            // Readiness already blocks commands while halt is held here.
            S_END: begin
                if (cmd_fire) begin
                    case (i_cmd)
                        CMD_RUN: begin
                            state_d   = S_START;
                            mode_d    = MODE_RUN;
                            count_clr = 1'b1;
                        end
                        CMD_STEP: begin
                            state_d   = S_START;
                            mode_d    = MODE_STEP;
                            count_clr = 1'b1;
                        end
                        CMD_ABORT: state_d = S_IDLE;
                        default:   state_d = S_END;
                    endcase
                end
            end
            default: begin
                state_d = S_IDLE;
                mode_d  = MODE_RUN;
            end
        endcase
    end

    // State and mode registers; reset aborts immediately with no drain.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_RUN;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    assign count_en = (state_q == S_RUN) || (state_q == S_STEP_PULSE);

    // Executed-cycle counter: counts enabled cycles, saturates rather than wrapping.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
        end else if (count_clr) begin
            count_q <= '0;
        end else if (count_en && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_ONE;
        end
    end

    assign o_start       = (state_q == S_START);
    assign o_enable      = count_en;
    assign o_running     = (state_q == S_START) || (state_q == S_RUN) ||
                           (state_q == S_STEP_WAIT) || (state_q == S_STEP_PULSE);
    assign o_end         = (state_q == S_END);
    assign o_cycle_count = count_q;

endmodule

// File: tb/tb_pc_exec_controller.sv
// Purpose: directed bench for pc_exec_controller with a scoreboard of expected observations.
// Latency: inputs driven 1 time unit after each rising edge; outputs sampled at the same point.
// Backpressure: command readiness is observed directly before and around command strobes.
module tb_pc_exec_controller;

    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic [1:0]  i_cmd = 2'b00;
    logic        i_program_ready = 1'b0;
    logic        i_halt = 1'b0;

    logic        o_cmd_ready, o_start, o_enable, o_running, o_end;
    logic [31:0] o_cycle_count;

    logic        n_cmd_ready, n_start, n_enable, n_running, n_end;
    logic [3:0]  n_cycle_count;

    pc_exec_controller #(.CYCLE_COUNT_SIZE(32)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
        .o_cmd_ready(o_cmd_ready), .i_program_ready(i_program_ready), .i_halt(i_halt),
        .o_start(o_start), .o_enable(o_enable), .o_running(o_running), .o_end(o_end),
        .o_cycle_count(o_cycle_count)
    );

    // Narrow-counter instance sharing all stimulus, used for the saturation check.
    pc_exec_controller #(.CYCLE_COUNT_SIZE(4)) dut4 (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
        .o_cmd_ready(n_cmd_ready), .i_program_ready(i_program_ready), .i_halt(i_halt),
        .o_start(n_start), .o_enable(n_enable), .o_running(n_running), .o_end(n_end),
        .o_cycle_count(n_cycle_count)
    );

    always #5 i_clk = ~i_clk;

    // Count cycles with start / enable high, sampled on the falling edge.
    int start_seen = 0;
    int en_seen    = 0;
    always @(negedge i_clk) begin
        if (o_start)  start_seen <= start_seen + 1;
        if (o_enable) en_seen    <= en_seen + 1;
    end

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   base_s, base_e;

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_v(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) n_pass++;
            else $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
        end
    endtask

    task automatic exp_outs(input string tag, input logic s, input logic en,
                            input logic run, input logic fin);
        expect_v({tag, ".start"},   {31'd0, s});
        expect_v({tag, ".enable"},  {31'd0, en});
        expect_v({tag, ".running"}, {31'd0, run});
        expect_v({tag, ".end"},     {31'd0, fin});
    endtask

    task automatic obs_outs();
        check_v({31'd0, o_start});
        check_v({31'd0, o_enable});
        check_v({31'd0, o_running});
        check_v({31'd0, o_end});
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        i_cmd_valid = 1'b1;
        i_cmd       = c;
        tick();
        i_cmd_valid = 1'b0;
        i_cmd       = 2'b00;
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        exp_outs("rst", 0, 0, 0, 0);
        expect_v("rst.count", 0);
        expect_v("rst.ready_noprog", 0);
        obs_outs();
        check_v(o_cycle_count);
        check_v({31'd0, o_cmd_ready});
        #2 i_reset_n = 1'b1;
        i_program_ready = 1'b1;
        tick();
        expect_v("idle.ready", 1);
        check_v({31'd0, o_cmd_ready});

        // RUN with halt raised on the 10th enabled cycle
        base_s = start_seen;
        base_e = en_seen;
        exp_outs("run.start", 1, 0, 1, 0);
        expect_v("run.start_ready", 0);
        send_cmd(CMD_RUN);
        obs_outs();
        check_v({31'd0, o_cmd_ready});
        tick();
        exp_outs("run.first_en", 0, 1, 1, 0);
        expect_v("run.first_count", 0);
        obs_outs();
        check_v(o_cycle_count);
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) i_halt = 1'b1;
            tick();
        end
        exp_outs("run.end", 0, 0, 0, 1);
        expect_v("run.count", 10);
        expect_v("run.en_cycles", 10);
        expect_v("run.start_cycles", 1);
        expect_v("run.end_ready_halt", 0);
        obs_outs();
        check_v(o_cycle_count);
        check_v(en_seen - base_e);
        check_v(start_seen - base_s);
        check_v({31'd0, o_cmd_ready});

        // END with halt held: RUN must not be accepted
        base_s = start_seen;
        i_cmd_valid = 1'b1;
        i_cmd = CMD_RUN;
        tick();
        i_cmd_valid = 1'b0;
        exp_outs("end_hold", 0, 0, 0, 1);
        expect_v("end_hold.no_start", 0);
        expect_v("end_hold.count", 10);
        obs_outs();
        check_v(start_seen - base_s);
        check_v(o_cycle_count);
        i_halt = 1'b0;
        #1;
        expect_v("end_free.ready", 1);
        check_v({31'd0, o_cmd_ready});
        exp_outs("restart.start", 1, 0, 1, 0);
        expect_v("restart.count_clr", 0);
        send_cmd(CMD_RUN);
        obs_outs();
        check_v(o_cycle_count);
        tick();
        exp_outs("restart.run", 0, 1, 1, 0);
        obs_outs();
        repeat (2) tick();
        expect_v("restart.count2", 2);
        check_v(o_cycle_count);

        // ABORT together with halt in RUN: abort wins
        i_halt = 1'b1;
        exp_outs("abort_halt", 0, 0, 0, 0);
        expect_v("abort_halt.count", 3);
        send_cmd(CMD_ABORT);
        obs_outs();
        check_v(o_cycle_count);
        i_halt = 1'b0;
        i_program_ready = 1'b0;
        #1;
        expect_v("noprog.ready", 0);
        check_v({31'd0, o_cmd_ready});
        send_cmd(CMD_RUN);
        exp_outs("noprog.ignored", 0, 0, 0, 0);
        obs_outs();
        i_program_ready = 1'b1;

        // STEP mode: three isolated single-cycle enables
        exp_outs("step.start", 1, 0, 1, 0);
        send_cmd(CMD_STEP);
        obs_outs();
        tick();
        exp_outs("step.wait", 0, 0, 1, 0);
        expect_v("step.wait_ready", 1);
        obs_outs();
        check_v({31'd0, o_cmd_ready});
        base_e = en_seen;
        for (int s = 0; s < 3; s++) begin
            repeat (4) tick();
            exp_outs("step.pulse", 0, 1, 1, 0);
            expect_v("step.pulse_ready", 0);
            send_cmd(CMD_STEP);
            obs_outs();
            check_v({31'd0, o_cmd_ready});
            tick();
            expect_v("step.after_pulse_en", 0);
            check_v({31'd0, o_enable});
        end
        exp_outs("step.final", 0, 0, 1, 0);
        expect_v("step.count", 3);
        expect_v("step.en_cycles", 3);
        obs_outs();
        check_v(o_cycle_count);
        check_v(en_seen - base_e);

        // Two steps, then switch to continuous RUN, halt after 4 more enabled cycles
        exp_outs("mix.abort", 0, 0, 0, 0);
        send_cmd(CMD_ABORT);
        obs_outs();
        send_cmd(CMD_STEP);
        tick();
        for (int s = 0; s < 2; s++) begin
            send_cmd(CMD_STEP);
            tick();
        end
        expect_v("mix.count2", 2);
        check_v(o_cycle_count);
        base_e = en_seen;
        exp_outs("mix.run", 0, 1, 1, 0);
        send_cmd(CMD_RUN);
        obs_outs();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) i_halt = 1'b1;
            tick();
        end
        exp_outs("mix.end", 0, 0, 0, 1);
        expect_v("mix.count", 6);
        expect_v("mix.en_cycles", 4);
        obs_outs();
        check_v(o_cycle_count);
        check_v(en_seen - base_e);

        // Asynchronous reset mid-RUN, between clock edges
        i_halt = 1'b0;
        #1;
        send_cmd(CMD_RUN);
        repeat (3) tick();
        #2 i_reset_n = 1'b0;
        #1;
        exp_outs("async_rst", 0, 0, 0, 0);
        expect_v("async_rst.count", 0);
        expect_v("async_rst.count4", 0);
        obs_outs();
        check_v(o_cycle_count);
        check_v({28'd0, n_cycle_count});
        #2 i_reset_n = 1'b1;
        tick();

        // Saturation of the narrow counter over 20 enabled cycles
        send_cmd(CMD_RUN);
        tick();
        repeat (20) tick();
        expect_v("sat.count4", 15);
        expect_v("sat.count32", 20);
        expect_v("sat.enable4", 1);
        check_v({28'd0, n_cycle_count});
        check_v(o_cycle_count);
        check_v({31'd0, n_enable});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
